// File: rtl/sc_fir_pkg.sv
// Shared types and defaults for the stochastic-computing FIR accumulator.
// Holds the FSM state encoding and the tap-select width helper.
package sc_fir_pkg;

  localparam int N_DEF    = 10;
  localparam int TAPS_DEF = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // A single tap still needs a one-bit select so the port never collapses to zero width.
  function automatic int sel_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/sc_hwa_acc_if.sv
// Sample-in / count-out handshake bundle for sc_hwa_acc, plus the per-cycle
// random number and tap-selection inputs.
interface sc_hwa_acc_if
  import sc_fir_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TAPS = TAPS_DEF
);

  localparam int SW = sel_w(TAPS);

  logic [TAPS-1:0][N:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         r_y;
  logic [SW-1:0]        sel_tap;
  logic                 fold_sel;
  logic [N:0]           out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;

  modport master (
    output in_data, in_valid, r_y, sel_tap, fold_sel, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, r_y, sel_tap, fold_sel, out_ready,
    output in_ready, out_data, out_valid, busy
  );

endinterface

// File: rtl/sc_sng.sv
// Stochastic number generator bit: compares a binary sample against a random
// number and applies the coefficient sign.
module sc_sng #(
  parameter int N = 10
) (
  input  logic [N:0]   i_sample,
  input  logic [N-1:0] i_rand,
  input  logic         i_neg,
  input  logic         i_en,
  output logic         o_bit
);

  assign o_bit = i_en & ((i_sample > {1'b0, i_rand}) ^ i_neg);

endmodule

// File: rtl/sc_hwa_acc.sv
// Stochastic FIR accumulator: counts ones of a tap-multiplexed, sign-adjusted
// stochastic stream over 2^N cycles per captured sample set.
module sc_hwa_acc
  import sc_fir_pkg::*;
#(
  parameter int             N        = N_DEF,
  parameter int             TAPS     = TAPS_DEF,
  parameter logic [TAPS-1:0] NEG_MASK = '0,
  parameter bit             SYM      = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  sc_hwa_acc_if.slave   bus
);

  state_t               r_state;
  state_t               w_next;
  logic [TAPS-1:0][N:0] r_data;
  logic [N-1:0]         r_cnt;
  logic [N:0]           r_acc;

  int                   w_t;
  logic [N:0]           w_sample;
  logic                 w_neg;
  logic                 w_hit;
  logic                 w_bit;

  // Effective tap; a folded select below zero or any select past TAPS-1 leaves w_hit low.
  always_comb begin
    w_t      = int'(bus.sel_tap);
    w_sample = '0;
    w_neg    = 1'b0;
    w_hit    = 1'b0;
    if (SYM && bus.fold_sel) begin
      w_t = TAPS - 1 - int'(bus.sel_tap);
    end
    for (int k = 0; k < TAPS; k++) begin
      if (w_t == k) begin
        w_sample = r_data[k];
        w_neg    = NEG_MASK[k];
        w_hit    = 1'b1;
      end
    end
  end

  sc_sng #(.N(N)) u_sng (
    .i_sample (w_sample),
    .i_rand   (bus.r_y),
    .i_neg    (w_neg),
    .i_en     (w_hit),
    .o_bit    (w_bit)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)  w_next = S_RUN;
      S_RUN:   if (r_cnt == '1)   w_next = S_HOLD;
      S_HOLD:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.in_valid) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + N'(1);
        r_acc <= r_acc + (N+1)'(w_bit);
      end
    end
  end

  // Sample registers are pure datapath: loaded on the handshake, never reset.
  always_ff @(posedge clock) begin
    if (r_state == S_IDLE && bus.in_valid) begin
      r_data <= bus.in_data;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_RUN);
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.out_data  = r_acc;

endmodule

// File: tb/tb_sc_hwa_acc.sv
// Scoreboard bench for sc_hwa_acc (N=4, TAPS=3): one plain instance and one
// with NEG_MASK=3'b001 and SYM=1, driven from shared per-cycle stimulus.
module tb_sc_hwa_acc;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  sc_hwa_acc_if #(.N(4), .TAPS(3)) ifa ();
  sc_hwa_acc_if #(.N(4), .TAPS(3)) ifb ();

  logic [2:0][4:0] s_data;
  logic [3:0]      s_ry;
  logic [1:0]      s_sel;
  logic            s_fold;
  logic            va, vb, ra, rb;

  assign ifa.in_data   = s_data;
  assign ifa.r_y       = s_ry;
  assign ifa.sel_tap   = s_sel;
  assign ifa.fold_sel  = s_fold;
  assign ifa.in_valid  = va;
  assign ifa.out_ready = ra;
  assign ifb.in_data   = s_data;
  assign ifb.r_y       = s_ry;
  assign ifb.sel_tap   = s_sel;
  assign ifb.fold_sel  = s_fold;
  assign ifb.in_valid  = vb;
  assign ifb.out_ready = rb;

  sc_hwa_acc #(.N(4), .TAPS(3), .NEG_MASK(3'b000), .SYM(1'b0)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  sc_hwa_acc #(.N(4), .TAPS(3), .NEG_MASK(3'b001), .SYM(1'b1)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  typedef struct {
    int data;
    int rise;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   pva      = 1'b0;
  bit   pvb      = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares whatever the DUTs present against the queued expectations.
  always @(negedge clock) begin
    if (reset) begin
      pva = 1'b0;
      pvb = 1'b0;
    end else begin
      if (ifa.out_valid === 1'b1) begin
        chk("A_expected_result_pending", int'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          if (!pva) chk("A_out_valid_rise_cycle", cyc, qa[0].rise);
          chk("A_out_data", int'(ifa.out_data), qa[0].data);
          if (ifa.out_ready) void'(qa.pop_front());
        end
      end
      pva = (ifa.out_valid === 1'b1);
      if (ifb.out_valid === 1'b1) begin
        chk("B_expected_result_pending", int'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          if (!pvb) chk("B_out_valid_rise_cycle", cyc, qb[0].rise);
          chk("B_out_data", int'(ifb.out_data), qb[0].data);
          if (ifb.out_ready) void'(qb.pop_front());
        end
      end
      pvb = (ifb.out_valid === 1'b1);
    end
  end

  task automatic set_cyc(input int mode, input int i);
    s_fold = 1'b0;
    s_ry   = 4'($urandom_range(0, 15));
    case (mode)
      0: begin s_sel = 2'($urandom_range(0, 2)); s_fold = 1'($urandom_range(0, 1)); end
      1: begin s_sel = 2'd1; s_ry = 4'(i); end
      2: s_sel = 2'd0;
      3: begin s_sel = 2'd3; s_fold = 1'($urandom_range(0, 1)); end
      4: begin s_sel = 2'd0; s_fold = 1'b1; end
      5: begin s_sel = 2'd2; s_fold = 1'b1; end
      6: begin s_sel = 2'(i % 3); s_ry = 4'(i); end
      default: begin s_sel = 2'd2; s_ry = 4'(i); end
    endcase
  endtask

  task automatic wait_ready(input bit b);
    for (int n = 0; n < 40; n++) begin
      if ((b ? ifb.in_ready : ifa.in_ready) === 1'b1) return;
      @(posedge clock); #1;
    end
    chk("in_ready_timeout", 0, 1);
  endtask

  task automatic txn(input bit b, input int d0, input int d1, input int d2,
                     input int mode, input int req, input int hold_n);
    int k;
    wait_ready(b);
    s_data[0] = 5'(d0);
    s_data[1] = 5'(d1);
    s_data[2] = 5'(d2);
    if (b) vb = 1'b1; else va = 1'b1;
    if (hold_n > 0) begin
      if (b) rb = 1'b0; else ra = 1'b0;
    end
    @(posedge clock); #1;
    k  = cyc;
    va = 1'b0;
    vb = 1'b0;
    if (b) qb.push_back('{req, k + 16});
    else   qa.push_back('{req, k + 16});
    for (int i = 0; i < 16; i++) begin
      set_cyc(mode, i);
      @(posedge clock); #1;
    end
    for (int j = 0; j < hold_n; j++) begin
      s_data = '{5'd1, 5'd1, 5'd1};
      if (b) vb = 1'b1; else va = 1'b1;
      chk("hold_in_ready", int'(b ? ifb.in_ready : ifa.in_ready), 0);
      chk("hold_busy", int'(b ? ifb.busy : ifa.busy), 0);
      @(posedge clock); #1;
    end
    if (hold_n > 0) begin
      va = 1'b0; vb = 1'b0; ra = 1'b1; rb = 1'b1;
      @(posedge clock); #1;
      chk("after_hold_in_ready", int'(b ? ifb.in_ready : ifa.in_ready), 1);
      chk("ignored_in_valid_busy", int'(b ? ifb.busy : ifa.busy), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    va     = 1'b0; vb = 1'b0; ra = 1'b1; rb = 1'b1;
    s_data = '0; s_ry = '0; s_sel = '0; s_fold = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_A_in_ready",  int'(ifa.in_ready), 1);
    chk("reset_A_busy",      int'(ifa.busy), 0);
    chk("reset_A_out_valid", int'(ifa.out_valid), 0);
    chk("reset_A_out_data",  int'(ifa.out_data), 0);
    chk("reset_B_in_ready",  int'(ifb.in_ready), 1);
    chk("reset_B_out_valid", int'(ifb.out_valid), 0);
    chk("reset_B_out_data",  int'(ifb.out_data), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    txn(1'b0, 16, 16, 16, 0, 16, 0);   // full-scale samples, random taps
    txn(1'b0,  9,  5,  9, 1,  5, 0);   // tap 1 against a swept r_y
    txn(1'b0,  3, 12,  7, 6,  7, 0);   // rotating taps: 1 + 4 + 2
    txn(1'b0, 16, 16, 16, 3,  0, 0);   // out-of-range tap
    txn(1'b0,  0,  0,  0, 0,  0, 0);   // all-zero samples
    txn(1'b0,  1,  2, 10, 7, 10, 5);   // consumer stalls five cycles

    // Reset lands on the eighth RUN cycle; the partial count must vanish.
    wait_ready(1'b0);
    s_data = '{5'd16, 5'd16, 5'd16};
    va = 1'b1;
    @(posedge clock); #1;
    va = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_cyc(0, i);
      @(posedge clock); #1;
    end
    chk("midrun_busy_before_reset", int'(ifa.busy), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrun_reset_busy",      int'(ifa.busy), 0);
    chk("midrun_reset_in_ready",  int'(ifa.in_ready), 1);
    chk("midrun_reset_out_valid", int'(ifa.out_valid), 0);
    chk("midrun_reset_out_data",  int'(ifa.out_data), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    txn(1'b1,  0,  4,  4, 2, 16, 0);   // negative tap 0 with zero sample
    txn(1'b1,  0,  4, 16, 4, 16, 0);   // fold sel 0 onto tap 2
    txn(1'b1,  0,  4,  0, 5, 16, 0);   // fold sel 2 onto negative tap 0
    txn(1'b1,  9,  7,  9, 1,  7, 0);   // unfolded positive tap 1
    txn(1'b1, 16, 16, 16, 3,  0, 0);   // out-of-range, folded or not
    txn(1'b0, 16, 16, 16, 0, 16, 0);   // normal operation after reset

    for (int n = 0; n < 40; n++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clock); #1;
    end
    chk("scoreboard_drained", qa.size() + qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sc_hwa_acc.md
SC_HWA_ACC -- requirements
Module: sc_hwa_acc

Interface
REQ-001 SHALL have parameter N, default 10, meaning RNG width; the stream length is 2^N cycles.
REQ-002 SHALL have parameter TAPS, default 11, meaning the number of FIR taps.
REQ-003 SHALL have parameter NEG_MASK [TAPS-1:0], default 0, meaning taps whose stochastic bit is inverted (negative coefficient sign).
REQ-004 SHALL have parameter SYM, default 0; when 1, symmetric folding is enabled.
REQ-005 SHALL have ports: clock, input, 1 bit, sole clock; all logic on posedge.
REQ-006 SHALL have port: reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port: in_data, input, TAPS x (N+1) bits, unsigned binary tap samples.
REQ-008 SHALL have port: in_valid, input, 1 bit, in_data is valid.
REQ-009 SHALL have port: in_ready, output, 1 bit, block accepts a sample set.
REQ-010 SHALL have port: r_y, input, N bits, comparator random number, fresh each cycle.
REQ-011 SHALL have port: sel_tap, input, clog2(TAPS) bits, tap chosen this cycle by the external weight-selection source.
REQ-012 SHALL have port: fold_sel, input, 1 bit, mirror-tap select; used only when SYM=1.
REQ-013 SHALL have port: out_data, output, N+1 bits, ones count of the weighted stream.
REQ-014 SHALL have port: out_valid, output, 1 bit, out_data is valid.
REQ-015 SHALL have port: out_ready, input, 1 bit, consumer accepts out_data.
REQ-016 SHALL have port: busy, output, 1 bit, high while accumulating.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and HOLD.
- IDLE -> RUN on in_valid & in_ready.
- RUN -> HOLD when cnt == 2^N-1.
- HOLD -> IDLE on out_ready.
REQ-018 SHALL drive in_ready=1 only in IDLE, busy=1 only in RUN, and out_valid=1 only in HOLD.
REQ-019 SHALL capture in_data into an internal register on the IDLE handshake, and clear the N-bit cycle counter cnt and the (N+1)-bit accumulator acc in that same cycle.
REQ-020 SHALL, in each RUN cycle, form the effective tap t as follows.
- SYM=0: t = sel_tap.
- SYM=1: t = TAPS-1-sel_tap when fold_sel=1, otherwise t = sel_tap.
REQ-021 SHALL, in each RUN cycle, compute the stochastic bit b = (reg[t] > zero-extended r_y) XOR NEG_MASK[t], and add b to acc.
REQ-022 SHALL force b=0 when t >= TAPS (out-of-range tap).
REQ-023 SHALL increment cnt each RUN cycle; acc SHALL NOT wrap, since its maximum is 2^N, which fits in N+1 bits.
REQ-024 SHALL meet this timing: with the handshake at cycle T, RUN occupies cycles T+1 through T+2^N, and out_valid rises at T+2^N+1 with out_data = final acc.
REQ-025 SHALL hold out_data and out_valid stable in HOLD until out_ready is sampled high.
REQ-026 SHALL ignore in_valid outside IDLE; back-to-back throughput is one sample set per 2^N+2 cycles.
REQ-027 SHALL drive out_data from the accumulator register only, with no combinational path from inputs.

Reset
REQ-028 SHALL, on reset, set state=IDLE, cnt=0, acc=0, out_data=0, out_valid=0, busy=0 and in_ready=1 at the next edge.
REQ-029 SHALL treat reset as dominant over every other event, including reset mid-RUN or mid-HOLD; the partial result SHALL be discarded with no out_valid pulse.

Structure
REQ-030 SHALL take its FSM state enum and the default N/TAPS constants from the shared package sc_fir_pkg.
REQ-031 SHALL use one sub-module, sc_sng, which holds the per-bit comparator and sign XOR, with one instance per selected-tap path.

Verification (N=4, TAPS=3)
REQ-032 SHALL cover: all in_data=16, r_y random, sel_tap random 0..2 -> out_data=16, out_valid at T+17.
REQ-033 SHALL cover: in_data[1]=5, sel_tap=1, r_y sweeping 0..15 -> out_data=5.
REQ-034 SHALL cover: NEG_MASK=3'b001, in_data[0]=0, sel_tap=0 -> out_data=16.
REQ-035 SHALL cover: sel_tap=3 throughout -> out_data=0; and SYM=1, fold_sel=1, sel_tap=0, in_data[2]=16, in_data[0]=0 -> out_data=16.
REQ-036 SHALL cover: out_ready held low for 5 cycles in HOLD -> out_valid and out_data stable, in_ready=0, and a new in_valid is ignored.
REQ-037 SHALL cover: reset asserted at RUN cycle 8 -> next cycle busy=0, in_ready=1, out_valid=0, out_data=0.
